// File: rtl/sha1_msg_pad.sv
// ---------------------------------------------------------------------------
// sha1_msg_pad
//
// SHA-1 message padder sitting directly in front of the SHA-1 core inside the
// sha1_wb wishbone slave. Message words arrive big-endian, first byte in
// [31:24]. The padder forwards them and then appends the 0x80 marker, the zero
// fill and the 64-bit big-endian message bit length. The result leaves as
// 512-bit blocks, each streamed as sixteen words W0..W15. When the length
// field no longer fits in the current block, an extra block is produced, so
// the core only ever sees fully padded blocks.
//
// Optional feature:
//   SHA1_PAD_ABORT_EN  when defined, adds input 'abort'. abort=1 clears this
//                      block on the next edge exactly like wb_rst_i, taking
//                      precedence over any handshake in that cycle.
//                      When undefined there is no abort port.
//
// Parameters:
//   LEN_W        width of the bit-length counter; upper 64-LEN_W bits of the
//                length field are always zero, longer messages wrap
//
// Ports:
//   wb_clk_i     in   1   clock
//   wb_rst_i     in   1   synchronous active-high reset
//   abort        in   1   message abort (only with SHA1_PAD_ABORT_EN)
//   in_valid     in   1   input word valid
//   in_ready     out  1   input word accepted this cycle
//   in_data      in   32  message word, first byte in [31:24]
//   in_last      in   1   final word of the message
//   in_bytes     in   3   valid bytes of the final word (0..4)
//   out_valid    out  1   out_word valid
//   out_ready    in   1   core accepts out_word this cycle
//   out_word     out  32  block word W[out_idx]
//   out_idx      out  4   word index inside the block
//   out_blk_end  out  1   word is W15 of a block
//   out_msg_end  out  1   word is the last word of the message
//   busy         out  1   message in progress
// ---------------------------------------------------------------------------
module sha1_msg_pad #(
  parameter int LEN_W = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
`ifdef SHA1_PAD_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_idx,
  output logic        out_blk_end,
  output logic        out_msg_end,
  output logic        busy
);

  typedef enum logic [2:0] {
    PASS,
    MARK,
    ZERO,
    LEN_HI,
    LEN_LO
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  length;
  logic [3:0]        nxt_idx;
  logic [63:0]       len64;

  logic              clear;
  logic              out_free;

  logic [31:0]       tail_word;
  logic [LEN_W-1:0]  tail_bits;
  logic              tail_full;

  logic              emit;
  logic [31:0]       emit_word;
  logic              emit_msg_end;

`ifdef SHA1_PAD_ABORT_EN
  assign clear = wb_rst_i | abort;
`else
  assign clear = wb_rst_i;
`endif

  // The output register may take a new word when it is empty or its current
  // word is being consumed in this same cycle.
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == PASS) && out_free;

  assign len64 = 64'(length);

  // Shape the final message word: keep the valid leading bytes and place the
  // 0x80 marker right behind them. A full final word carries no marker; the
  // MARK state adds a separate marker word afterwards.
  always_comb begin
    tail_word = in_data;
    tail_bits = LEN_W'(32);
    tail_full = 1'b1;
    case (in_bytes)
      3'd0: begin
        tail_word = 32'h8000_0000;
        tail_bits = '0;
        tail_full = 1'b0;
      end
      3'd1: begin
        tail_word = {in_data[31:24], 24'h80_0000};
        tail_bits = LEN_W'(8);
        tail_full = 1'b0;
      end
      3'd2: begin
        tail_word = {in_data[31:16], 16'h8000};
        tail_bits = LEN_W'(16);
        tail_full = 1'b0;
      end
      3'd3: begin
        tail_word = {in_data[31:8], 8'h80};
        tail_bits = LEN_W'(24);
        tail_full = 1'b0;
      end
      default: begin
        tail_word = in_data;
        tail_bits = LEN_W'(32);
        tail_full = 1'b1;
      end
    endcase
  end

  // Word the current state would like to emit. It is only loaded into the
  // output register when out_free is set. ZERO stops emitting as soon as the
  // next index is 14, because W14/W15 belong to the length field.
  always_comb begin
    emit         = 1'b0;
    emit_word    = 32'h0;
    emit_msg_end = 1'b0;
    case (state)
      PASS: begin
        emit      = in_valid;
        emit_word = in_last ? tail_word : in_data;
      end
      MARK: begin
        emit      = 1'b1;
        emit_word = 32'h8000_0000;
      end
      ZERO: begin
        emit      = (nxt_idx != 4'd14);
        emit_word = 32'h0;
      end
      LEN_HI: begin
        emit      = 1'b1;
        emit_word = len64[63:32];
      end
      LEN_LO: begin
        emit         = 1'b1;
        emit_word    = len64[31:0];
        emit_msg_end = 1'b1;
      end
      default: begin
        emit = 1'b0;
      end
    endcase
  end

  // Padding FSM with registered output stage. nxt_idx is the index that the
  // next emitted word will carry; it wraps naturally at 16, which is what
  // pushes the length field into a second block when the marker lands at
  // W14 or W15.
  always_ff @(posedge wb_clk_i) begin
    if (clear) begin
      state       <= PASS;
      length      <= '0;
      nxt_idx     <= 4'd0;
      out_valid   <= 1'b0;
      out_word    <= 32'h0;
      out_idx     <= 4'd0;
      out_blk_end <= 1'b0;
      out_msg_end <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (out_free) begin
        out_valid <= emit;
        if (emit) begin
          out_word    <= emit_word;
          out_idx     <= nxt_idx;
          out_blk_end <= (nxt_idx == 4'd15);
          out_msg_end <= emit_msg_end;
          nxt_idx     <= nxt_idx + 4'd1;
        end
      end

      // A new message word wins over the end of the previous message.
      if (in_valid && in_ready) begin
        busy <= 1'b1;
      end else if (out_valid && out_ready && out_msg_end) begin
        busy <= 1'b0;
      end

      case (state)
        PASS: begin
          if (in_valid && out_free) begin
            length <= length + (in_last ? tail_bits : LEN_W'(32));
            if (in_last) begin
              state <= tail_full ? MARK : ZERO;
            end
          end
        end
        MARK: begin
          if (out_free) begin
            state <= ZERO;
          end
        end
        ZERO: begin
          if (nxt_idx == 4'd14) begin
            state <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (out_free) begin
            state <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (out_free) begin
            length <= '0;
            state  <= PASS;
          end
        end
        default: begin
          state <= PASS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_pad.sv
// ---------------------------------------------------------------------------
// tb_sha1_msg_pad
//
// Self-checking bench for sha1_msg_pad. Messages are byte queues; a byte-level
// padding model (append 0x80, zero until length = 56 mod 64, append the 64-bit
// bit length) produces the expected words, which are queued when a message is
// issued. A monitor drives a random out_ready and pops/compares each
// transferred word. With SHA1_PAD_ABORT_EN defined the abort input is also
// exercised.
// ---------------------------------------------------------------------------
module tb_sha1_msg_pad;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        be;
    logic        me;
  } beat_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic [2:0]  in_bytes = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [3:0]  out_idx;
  logic        out_blk_end;
  logic        out_msg_end;
  logic        busy;
`ifdef SHA1_PAD_ABORT_EN
  logic        abort_drv = 1'b0;
`endif

  beat_t       sb_q[$];
  logic [31:0] got_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          flush_req = 1'b0;
  int          ready_pct10 = 10;

  always #5 wb_clk_i = ~wb_clk_i;

  sha1_msg_pad #(.LEN_W(32)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
`ifdef SHA1_PAD_ABORT_EN
    .abort       (abort_drv),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_idx     (out_idx),
    .out_blk_end (out_blk_end),
    .out_msg_end (out_msg_end),
    .busy        (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: pad the message at byte level and queue the words.
  function automatic void push_expected(input byte_q_t msg);
    byte_q_t         p;
    longint unsigned bits;
    int              nw;
    beat_t           b;
    p    = msg;
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    nw = p.size() / 4;
    for (int i = 0; i < nw; i++) begin
      b.w   = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
      b.idx = 4'(i % 16);
      b.be  = ((i % 16) == 15);
      b.me  = (i == nw - 1);
      sb_q.push_back(b);
    end
  endfunction

  function automatic byte_q_t rand_msg(input int len);
    byte_q_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom()));
    return m;
  endfunction

  // Monitor: choose out_ready for the coming edge, then score the word that
  // will transfer on it.
  initial begin
    beat_t e;
    forever begin
      @(negedge wb_clk_i);
      #2;
      out_ready = ($urandom_range(0, 9) < ready_pct10);
      if (!wb_rst_i && !flush_req && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word actual=%h idx=%0d expected=none", out_word, out_idx);
        end else begin
          e = sb_q.pop_front();
          checkOutput("out_beat", {out_word, out_idx, out_blk_end, out_msg_end},
                      {e.w, e.idx, e.be, e.me});
          got_q.push_back(out_word);
        end
      end
    end
  end

  // Issue one message. cut_at >= 0 stops after that many accepted words and
  // clears the block with wb_rst_i (or abort).
  task automatic applyStimulus(input byte_q_t msg, input bit use_term, input int cut_at,
                               input bit use_abort);
    logic [31:0] wd[$];
    logic        lst[$];
    logic [2:0]  nb[$];
    logic [31:0] w;
    int          len, nfull, rem, i, budget;
    bit          chk_busy;
    len   = msg.size();
    nfull = len / 4;
    rem   = len % 4;
    for (int k = 0; k < nfull; k++) begin
      wd.push_back({msg[4*k], msg[4*k+1], msg[4*k+2], msg[4*k+3]});
      lst.push_back(1'b0);
      nb.push_back(3'd4);
    end
    if (rem != 0) begin
      w = $urandom();
      for (int b = 0; b < rem; b++) w[31-8*b -: 8] = msg[4*nfull+b];
      wd.push_back(w);
      lst.push_back(1'b1);
      nb.push_back(3'(rem));
    end else if (len == 0 || use_term) begin
      wd.push_back($urandom());
      lst.push_back(1'b1);
      nb.push_back(3'd0);
    end else begin
      lst[lst.size()-1] = 1'b1;
    end
    push_expected(msg);
    i        = 0;
    budget   = 0;
    chk_busy = 1'b0;
    while (i < wd.size()) begin
      @(negedge wb_clk_i);
      if (chk_busy) begin
        checkOutput("busy_mid", busy, 1);
        chk_busy = 1'b0;
      end
      if (cut_at >= 0 && i == cut_at) break;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = wd[i];
      in_last  = lst[i];
      in_bytes = nb[i];
      #3;
      if (in_valid && in_ready) begin
        if (i == 0) chk_busy = 1'b1;
        i++;
      end
      budget++;
      if (budget > 5000) begin
        checks++;
        errors++;
        $display("[TB] FAIL input_timeout actual=%0d words expected=%0d", i, wd.size());
        break;
      end
    end
    if (cut_at >= 0 && i == cut_at) begin
      in_valid  = 1'b0;
      flush_req = 1'b1;
`ifdef SHA1_PAD_ABORT_EN
      if (use_abort) abort_drv = 1'b1;
      else wb_rst_i = 1'b1;
`else
      if (!use_abort) wb_rst_i = 1'b1;
`endif
      @(negedge wb_clk_i);
      checkOutput("cut_valid", out_valid, 0);
      checkOutput("cut_idx", out_idx, 0);
      checkOutput("cut_busy", busy, 0);
      wb_rst_i = 1'b0;
`ifdef SHA1_PAD_ABORT_EN
      abort_drv = 1'b0;
`endif
      sb_q.delete();
      got_q.delete();
      flush_req = 1'b0;
    end else begin
      @(negedge wb_clk_i);
      if (chk_busy) checkOutput("busy_mid", busy, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 3000) begin
      @(negedge wb_clk_i);
      budget++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drain actual=%0d pending expected=0", name, sb_q.size());
    end
    repeat (2) @(negedge wb_clk_i);
    checkOutput({name, "_idle_valid"}, out_valid, 0);
    checkOutput({name, "_idle_busy"}, busy, 0);
  endtask

  task automatic checkAbc();
    byte_q_t m;
    m = '{8'h61, 8'h62, 8'h63};
    got_q.delete();
    applyStimulus(m, 1'b0, -1, 1'b0);
    waitDrain("abc");
    checkOutput("abc_words", got_q.size(), 16);
    if (got_q.size() == 16) begin
      checkOutput("abc_w0", got_q[0], 32'h6162_6380);
      checkOutput("abc_w15", got_q[15], 32'h0000_0018);
    end
  endtask

  initial begin
    byte_q_t m;
    #600000;
    $display("[TB] FAIL global_timeout actual=stuck expected=finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    byte_q_t m;
    // Reset state
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_word", out_word, 0);
    checkOutput("rst_idx", out_idx, 0);
    checkOutput("rst_blk_end", out_blk_end, 0);
    checkOutput("rst_msg_end", out_msg_end, 0);
    checkOutput("rst_busy", busy, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    #3;
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] abc");
    ready_pct10 = 10;
    checkAbc();

    $display("[TB] empty message");
    got_q.delete();
    m = {};
    applyStimulus(m, 1'b1, -1, 1'b0);
    waitDrain("empty");
    checkOutput("empty_words", got_q.size(), 16);
    if (got_q.size() == 16) checkOutput("empty_w0", got_q[0], 32'h8000_0000);

    $display("[TB] 55 bytes");
    got_q.delete();
    ready_pct10 = 8;
    applyStimulus(rand_msg(55), 1'b0, -1, 1'b0);
    waitDrain("b55");
    checkOutput("b55_words", got_q.size(), 16);
    if (got_q.size() == 16) begin
      checkOutput("b55_w13_mark", got_q[13][7:0], 8'h80);
      checkOutput("b55_w15", got_q[15], 32'h0000_01B8);
    end

    $display("[TB] 56 bytes");
    got_q.delete();
    applyStimulus(rand_msg(56), 1'b0, -1, 1'b0);
    waitDrain("b56");
    checkOutput("b56_words", got_q.size(), 32);
    if (got_q.size() == 32) begin
      checkOutput("b56_w14", got_q[14], 32'h8000_0000);
      checkOutput("b56_w15", got_q[15], 32'h0);
      checkOutput("b56_b2w15", got_q[31], 32'h0000_01C0);
    end

    $display("[TB] 64 bytes, random backpressure");
    got_q.delete();
    ready_pct10 = 5;
    applyStimulus(rand_msg(64), 1'b0, -1, 1'b0);
    waitDrain("b64");
    checkOutput("b64_words", got_q.size(), 32);
    if (got_q.size() == 32) begin
      checkOutput("b64_b2w0", got_q[16], 32'h8000_0000);
      checkOutput("b64_b2w15", got_q[31], 32'h0000_0200);
    end

    $display("[TB] reset mid-message");
    ready_pct10 = 10;
    applyStimulus(rand_msg(40), 1'b0, 8, 1'b0);
    checkAbc();

`ifdef SHA1_PAD_ABORT_EN
    $display("[TB] abort mid-message");
    applyStimulus(rand_msg(40), 1'b0, 8, 1'b1);
    checkAbc();
`endif

    $display("[TB] random messages");
    for (int n = 0; n < 30; n++) begin
      ready_pct10 = $urandom_range(3, 10);
      applyStimulus(rand_msg($urandom_range(0, 150)), 1'($urandom_range(0, 1)), -1, 1'b0);
      if ((n % 5) == 4) waitDrain("rand");
    end
    waitDrain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
